// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes 16-bit big-endian words into instruction memory
// and holds the processor in reset until a load completes with a good XOR checksum.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [15:0]           mem_wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, ERR} state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d, csum_q, csum_d;
    logic [ADDR_WIDTH:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           data_q, data_d, n_rx;
    logic                  wr_en_q, wr_en_d, hold_q, hold_d, busy_q, busy_d;
    logic                  done_q, done_d, err_q, err_d, accept;

    assign in_ready    = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA_HI) ||
                         (state_q == DATA_LO) || (state_q == CHECK);
    assign accept      = in_valid && in_ready;
    assign n_rx        = {hi_q, in_data};
    assign cnt_inc     = cnt_q + 1'b1;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign cpu_hold    = hold_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        hold_d  = hold_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    len_d  = n_rx[ADDR_WIDTH:0];
                    // Oversized counts abort before any write is issued.
                    if ({1'b0, n_rx} > MAX_N) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = (n_rx == '0) ? CHECK : DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    wr_en_d = 1'b1;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    data_d  = {hi_q, in_data};
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            csum_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames checked by a scoreboard fed from a frame-level reference model.
module tb_imem_loader;
    localparam int MAXW = 1024;

    typedef struct packed {
        logic [1:0]  kind;
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, mem_wr_en, cpu_hold, busy, done, error;
    logic [7:0]  in_data;
    logic [9:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;

    exp_t       exp_q[$];
    logic [7:0] frame_q[$];
    int         checks = 0;
    int         failures = 0;
    int         last_addr = -1;

    imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // kind: 0 = write, 1 = done pulse, 2 = error rising
    task automatic observe(input logic [1:0] kind, input logic [9:0] a, input logic [15:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h expected nothing", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 2'd0 && (e.addr != a || e.data != d))) begin
                failures++;
                $display("FAIL event: got kind=%0d addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_wr_en) begin
                observe(2'd0, mem_wr_addr, mem_wr_data);
                last_addr = int'(mem_wr_addr);
            end
            if (done) observe(2'd1, '0, '0);
            if (error && !prev_err) observe(2'd2, '0, '0);
            prev_err = error;
        end
    end

    function automatic exp_t mk(input logic [1:0] k, input int a, input logic [15:0] d);
        exp_t e;
        e.kind = k;
        e.addr = 10'(a);
        e.data = d;
        return e;
    endfunction

    // Reference model: outcome of a whole frame from the framing and checksum rules.
    task automatic predict(output int nsend, output bit ok);
        int n;
        logic [7:0] x;
        n = int'({frame_q[0], frame_q[1]});
        if (n > MAXW) begin
            exp_q.push_back(mk(2'd2, 0, '0));
            nsend = 2;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(mk(2'd0, i, {frame_q[2 + 2 * i], frame_q[3 + 2 * i]}));
            x = '0;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= frame_q[i];
            ok = (frame_q[2 + 2 * n] == x);
            exp_q.push_back(mk(ok ? 2'd1 : 2'd2, 0, '0));
            nsend = 3 + 2 * n;
        end
    endtask

    task automatic add_ck(input bit good);
        logic [7:0] x;
        x = '0;
        foreach (frame_q[i]) x ^= frame_q[i];
        frame_q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        bit acc;
        gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = b;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: byte %0h not accepted, required accept within 50 cycles", b);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_err", error, 0);
    endtask

    task automatic send_frame(input int maxgap);
        int nsend;
        bit ok;
        predict(nsend, ok);
        do_start();
        for (int i = 0; i < nsend; i++) send_byte(frame_q[i], maxgap);
        in_valid = 1'b0;
        if (!ok) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            repeat (4) begin @(posedge clk); #1; end
            in_valid = 1'b0;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("drain", exp_q.size(), 0);
        chk("end_hold", cpu_hold, ok ? 0 : 1);
        chk("end_err", error, ok ? 0 : 1);
        chk("end_busy", busy, 0);
        if (!ok) chk("end_ready", in_ready, 0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_wren"}, mem_wr_en, 0);
        chk({tag, "_addr"}, mem_wr_addr, 0);
        chk({tag, "_data"}, mem_wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_hold"}, cpu_hold, 1);
    endtask

    initial begin
        logic [15:0] n;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(0);
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_frame(0);
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        frame_q = '{8'h04, 8'h01};
        send_frame(0);
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(1);
        send_frame(3);

        for (int f = 0; f < 20; f++) begin
            n = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(MAXW + 1, 65535)) : 16'($urandom_range(0, 6));
            frame_q = '{n[15:8], n[7:0]};
            if (int'(n) <= MAXW) begin
                for (int i = 0; i < 2 * int'(n); i++) frame_q.push_back(8'($urandom));
                add_ck($urandom_range(0, 2) != 0);
            end
            send_frame($urandom_range(0, 3));
        end

        frame_q = '{8'h04, 8'h00};
        for (int i = 0; i < MAXW; i++) begin
            frame_q.push_back(8'(i >> 8));
            frame_q.push_back(8'(i));
        end
        add_ck(1'b1);
        send_frame(0);
        chk("last_addr", last_addr, MAXW - 1);

        do_start();
        exp_q.push_back(mk(2'd0, 0, 16'h1234));
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        reset_vals("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_drain", exp_q.size(), 0);
        chk("midrst_hold_after", cpu_hold, 1);

        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
